raymarch_frame_scheduler: RTL and testbench
===========================================

RAYMARCH_FRAME_SCHEDULER -- requirements
Module: raymarch_frame_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 SHALL have parameter LATENCY, default 32, raymarcher pixel-to-color pipeline depth in clk cycles; legal range >=1.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request to render one frame; sampled in IDLE only.
REQ-007 continuous  in  1  when high, DONE goes straight to LOAD.
REQ-008 cam_wr  in  1  camera shadow register write strobe.
REQ-009 cam_addr  in  4  0-8 = look_at_1_1..look_at_3_3 in row-major order, 9-11 = eye_x/eye_y/eye_z; 12-15 ignored.
REQ-010 cam_wdata  in  27  27-bit float write data.
REQ-011 look_at_1_1..look_at_3_3, eye_x, eye_y, eye_z  out  27 each  active camera values driven to raymarcher.
REQ-012 pixel_x  out  10  issued pixel column; pixel_y  out  10  issued pixel row.
REQ-013 red, green, blue  in  8 each  raymarcher color output.
REQ-014 fb_we  out  1  framebuffer write enable; fb_addr  out  19  write address; fb_data  out  24  {red,green,blue}.
REQ-015 busy  out  1; frame_done  out  1 (single-cycle pulse); frame_count  out  16.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, ISSUE, DRAIN, DONE.
REQ-017 IDLE->LOAD when start=1; LOAD lasts exactly 1 cycle, then ISSUE.
REQ-018 LOAD SHALL copy all 12 shadow registers into active outputs; active outputs SHALL NOT change in any other state.
REQ-019 cam_wr SHALL update the addressed shadow register in any state; a write in the LOAD cycle SHALL NOT be visible until the next LOAD.
REQ-020 ISSUE SHALL present one pixel per cycle, raster order, x fastest: (0,0),(1,0)..(H_RES-1,0),(0,1)..(H_RES-1,V_RES-1); exactly H_RES*V_RES cycles.
REQ-021 Issue address SHALL be y*H_RES+x, maintained incrementally (no multiplier), range 0..H_RES*V_RES-1.
REQ-022 A LATENCY-stage delay line SHALL carry {valid, address}; fb_we/fb_addr SHALL equal the values issued LATENCY cycles earlier.
REQ-023 fb_data SHALL be {red,green,blue} sampled combinationally in the cycle fb_we is high.
REQ-024 ISSUE->DRAIN after the last pixel; DRAIN SHALL last until the final delayed write has been output (LATENCY cycles), then DONE.
REQ-025 DONE lasts 1 cycle: frame_done=1, frame_count+=1 (wraps 65535->0); next state LOAD if continuous=1, else IDLE.
REQ-026 busy=1 in LOAD, ISSUE, DRAIN, DONE; 0 in IDLE.
REQ-027 start outside IDLE SHALL be ignored (not queued).
REQ-028 Outside ISSUE, pixel_x=0, pixel_y=0, and no valid SHALL enter the delay line.
REQ-029 fb_we SHALL be asserted exactly H_RES*V_RES times per frame, each address exactly once.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force: state IDLE, pixel_x=pixel_y=0, fb_we=0, fb_addr=0, busy=0, frame_done=0, frame_count=0, all delay-line valids 0.
REQ-031 Reset SHALL set shadow and active look_at_1_1, look_at_2_2, look_at_3_3 = 27'h1FC0000 (1.0); all other camera registers = 0.
REQ-032 Reset mid-frame SHALL abort it: no fb_we in any cycle after the reset edge until a new frame is issued.

Verification
REQ-033 Reset: hold rst_n=0 2 cycles -> busy=0, fb_we=0, frame_count=0, look_at_1_1=27'h1FC0000, eye_x=0.
REQ-034 Single frame, H_RES=8, V_RES=4, LATENCY=4: start pulse -> LOAD 1 cycle, 32 ISSUE cycles, first fb_we (addr 0) 4 cycles after first issue, last fb_we addr 31, frame_done 1 cycle after DRAIN ends, frame_count=1, busy=0 after.
REQ-035 Shadow: cam_wr addr 9 data 27'h1FC0000 mid-ISSUE -> eye_x stays 0 until next LOAD, then 27'h1FC0000; cam_addr 12 write -> no output change.
REQ-036 Continuous=1 over 3 frames -> DONE->LOAD with no IDLE cycle, frame_count 1,2,3, 3*32 fb_we total.
REQ-037 Reset at issue index 10 -> fb_we 0 from next cycle; restart via start -> first write addr 0.
REQ-038 start pulses during ISSUE/DRAIN -> ignored; exactly one frame_done per accepted start.

Source files
------------

// File: rtl/raymarch_frame_scheduler.sv
// Frame scheduler for a pipelined raymarcher: issues pixels in raster
// order, delays {valid,addr} by LATENCY and writes colors to framebuffer.
// Ports: clk, rst_n (sync, active-low); start/continuous frame control;
//   cam_wr/cam_addr/cam_wdata shadow camera writes; look_at_* / eye_*
//   active camera; pixel_x/pixel_y issued pixel; red/green/blue color in;
//   fb_we/fb_addr/fb_data framebuffer write; busy, frame_done, frame_count.
module raymarch_frame_scheduler #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        cam_wr,
    input  logic [3:0]  cam_addr,
    input  logic [26:0] cam_wdata,
    output logic [26:0] look_at_1_1,
    output logic [26:0] look_at_1_2,
    output logic [26:0] look_at_1_3,
    output logic [26:0] look_at_2_1,
    output logic [26:0] look_at_2_2,
    output logic [26:0] look_at_2_3,
    output logic [26:0] look_at_3_1,
    output logic [26:0] look_at_3_2,
    output logic [26:0] look_at_3_3,
    output logic [26:0] eye_x,
    output logic [26:0] eye_y,
    output logic [26:0] eye_z,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, DRAIN, DONE
    } state_t;

    localparam logic [26:0] ONE = 27'h1FC0000;
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(LATENCY - 1);

    state_t state_q, state_d;
    logic [9:0]  x_q, y_q;
    logic [18:0] a_q;
    logic [DW-1:0] d_q;
    logic        last_px;
    logic        issue;

    logic [LATENCY-1:0] vld_q;
    logic [18:0] dadr_q [LATENCY];

    logic [26:0] shd_q [12];
    logic [26:0] act_q [12];

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ISSUE;
            ISSUE:   if (last_px) state_d = DRAIN;
            DRAIN:   if (d_q == D_LAST) state_d = DONE;
            DONE:    state_d = continuous ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        issue      = (state_q == ISSUE);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        pixel_x    = issue ? x_q : 10'd0;
        pixel_y    = issue ? y_q : 10'd0;
    end

    // Raster counters; address tracks y*H_RES+x by plain increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            a_q <= '0;
            d_q <= '0;
        end else begin
            if (issue) begin
                a_q <= a_q + 19'd1;
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end else begin
                x_q <= '0;
                y_q <= '0;
                a_q <= '0;
            end
            if (state_q == DRAIN) d_q <= d_q + DW'(1);
            else                  d_q <= '0;
        end
    end

    // Delay line matching the raymarcher pipeline depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) dadr_q[i] <= '0;
        end else begin
            vld_q[0]  <= issue;
            dadr_q[0] <= a_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                dadr_q[i] <= dadr_q[i-1];
            end
        end
    end

    assign fb_we   = vld_q[LATENCY-1];
    assign fb_addr = dadr_q[LATENCY-1];
    assign fb_data = {red, green, blue};

    // Shadow camera registers, writable at any time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++)
                shd_q[i] <= (i == 0 || i == 4 || i == 8) ? ONE : '0;
        end else if (cam_wr && cam_addr < 4'd12) begin
            shd_q[cam_addr] <= cam_wdata;
        end
    end

    // Active camera: snapshot of the shadow set taken only in LOAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++)
                act_q[i] <= (i == 0 || i == 4 || i == 8) ? ONE : '0;
        end else if (state_q == LOAD) begin
            act_q <= shd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                frame_count <= '0;
        else if (state_q == DONE)  frame_count <= frame_count + 16'd1;
    end

    assign look_at_1_1 = act_q[0];
    assign look_at_1_2 = act_q[1];
    assign look_at_1_3 = act_q[2];
    assign look_at_2_1 = act_q[3];
    assign look_at_2_2 = act_q[4];
    assign look_at_2_3 = act_q[5];
    assign look_at_3_1 = act_q[6];
    assign look_at_3_2 = act_q[7];
    assign look_at_3_3 = act_q[8];
    assign eye_x       = act_q[9];
    assign eye_y       = act_q[10];
    assign eye_z       = act_q[11];

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Directed bench for raymarch_frame_scheduler (8x4 frame, latency 4).
// Each task drives one scenario and checks hand-computed expectations.
module tb_raymarch_frame_scheduler;

    localparam logic [26:0] ONE = 27'h1FC0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        cam_wr = 1'b0;
    logic [3:0]  cam_addr = '0;
    logic [26:0] cam_wdata = '0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic [26:0] look_at_1_1, look_at_1_2, look_at_1_3;
    logic [26:0] look_at_2_1, look_at_2_2, look_at_2_3;
    logic [26:0] look_at_3_1, look_at_3_2, look_at_3_3;
    logic [26:0] eye_x, eye_y, eye_z;
    logic [9:0]  pixel_x, pixel_y;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic        busy, frame_done;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int done_total = 0;

    raymarch_frame_scheduler #(.H_RES(8), .V_RES(4), .LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .cam_wr(cam_wr), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
        .look_at_1_1(look_at_1_1), .look_at_1_2(look_at_1_2),
        .look_at_1_3(look_at_1_3), .look_at_2_1(look_at_2_1),
        .look_at_2_2(look_at_2_2), .look_at_2_3(look_at_2_3),
        .look_at_3_1(look_at_3_1), .look_at_3_2(look_at_3_2),
        .look_at_3_3(look_at_3_3), .eye_x(eye_x), .eye_y(eye_y),
        .eye_z(eye_z), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .red(red), .green(green), .blue(blue), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_we) wr_total++;
        if (frame_done) done_total++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
        checks++; if (fb_addr !== 19'd0) begin errors++; $display("FAIL reset_fb_addr got %0d want 0", fb_addr); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", frame_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
        checks++; if (look_at_1_1 !== ONE) begin errors++; $display("FAIL reset_la11 got %h want %h", look_at_1_1, ONE); end
        checks++; if (look_at_2_2 !== ONE) begin errors++; $display("FAIL reset_la22 got %h want %h", look_at_2_2, ONE); end
        checks++; if (look_at_3_3 !== ONE) begin errors++; $display("FAIL reset_la33 got %h want %h", look_at_3_3, ONE); end
        checks++; if (look_at_1_2 !== 27'd0) begin errors++; $display("FAIL reset_la12 got %h want 0", look_at_1_2); end
        checks++; if (eye_x !== 27'd0) begin errors++; $display("FAIL reset_eye_x got %h want 0", eye_x); end
        checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL reset_pixel got %0d,%0d want 0,0", pixel_x, pixel_y); end
        rst_n = 1'b1;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame;
        do_reset;
        red = 8'h12; green = 8'h34; blue = 8'h56;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL load_fb_we got %b want 0", fb_we); end
        for (int k = 0; k < 32; k++) begin
            step;
            checks++; if (pixel_x !== 10'(k % 8) || pixel_y !== 10'(k / 8)) begin errors++; $display("FAIL issue_pixel k=%0d got %0d,%0d want %0d,%0d", k, pixel_x, pixel_y, k % 8, k / 8); end
            checks++; if (fb_we !== (k >= 4)) begin errors++; $display("FAIL issue_we k=%0d got %b want %b", k, fb_we, k >= 4); end
            if (k >= 4) begin
                checks++; if (fb_addr !== 19'(k - 4)) begin errors++; $display("FAIL issue_addr k=%0d got %0d want %0d", k, fb_addr, k - 4); end
            end
        end
        for (int d = 0; d < 4; d++) begin
            step;
            checks++; if (fb_we !== 1'b1 || fb_addr !== 19'(28 + d)) begin errors++; $display("FAIL drain_wr d=%0d got %b/%0d want 1/%0d", d, fb_we, fb_addr, 28 + d); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL drain_done d=%0d got %b want 0", d, frame_done); end
            checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL drain_pixel got %0d,%0d want 0,0", pixel_x, pixel_y); end
        end
        checks++; if (fb_data !== 24'h123456) begin errors++; $display("FAIL fb_data got %h want 123456", fb_data); end
        step;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", frame_done); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL done_we got %b want 0", fb_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_busy got %b want 1", busy); end
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL after_done got %b want 0", frame_done); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL after_count got %0d want 1", frame_count); end
    endtask

    task automatic test_shadow;
        int n;
        do_reset;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (5) step;
        cam_wr = 1'b1; cam_addr = 4'd9; cam_wdata = ONE;
        step;
        cam_addr = 4'd12; cam_wdata = 27'h7FFFFFF;
        step;
        cam_wr = 1'b0;
        checks++; if (eye_x !== 27'd0) begin errors++; $display("FAIL shadow_hidden got %h want 0", eye_x); end
        n = 0;
        while (busy && n < 200) begin step; n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shadow_timeout1 busy got %b want 0", busy); end
        checks++; if (eye_x !== 27'd0) begin errors++; $display("FAIL shadow_idle got %h want 0", eye_x); end
        start = 1'b1;
        step;
        start = 1'b0;
        cam_wr = 1'b1; cam_addr = 4'd10; cam_wdata = 27'h123;
        checks++; if (eye_x !== 27'd0) begin errors++; $display("FAIL shadow_in_load got %h want 0", eye_x); end
        step;
        cam_wr = 1'b0;
        checks++; if (eye_x !== ONE) begin errors++; $display("FAIL shadow_loaded got %h want %h", eye_x, ONE); end
        checks++; if (eye_y !== 27'd0) begin errors++; $display("FAIL shadow_load_write got %h want 0", eye_y); end
        checks++; if (eye_z !== 27'd0 || look_at_1_2 !== 27'd0 || look_at_3_2 !== 27'd0) begin errors++; $display("FAIL shadow_addr12 got %h/%h/%h want 0", eye_z, look_at_1_2, look_at_3_2); end
        checks++; if (look_at_1_1 !== ONE || look_at_2_2 !== ONE || look_at_3_3 !== ONE) begin errors++; $display("FAIL shadow_diag got %h/%h/%h want %h", look_at_1_1, look_at_2_2, look_at_3_3, ONE); end
        n = 0;
        while (busy && n < 200) begin step; n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shadow_timeout2 busy got %b want 0", busy); end
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        checks++; if (eye_y !== 27'h123) begin errors++; $display("FAIL shadow_next_load got %h want 123", eye_y); end
        n = 0;
        while (busy && n < 200) begin step; n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shadow_timeout3 busy got %b want 0", busy); end
    endtask

    task automatic test_continuous;
        int base, dn, n, idle_seen;
        do_reset;
        base = wr_total;
        dn = 0; n = 0; idle_seen = 0;
        continuous = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        while (dn < 3 && n < 300) begin
            if (!busy) idle_seen++;
            if (frame_done) begin
                dn++;
                checks++; if (frame_count !== 16'(dn - 1)) begin errors++; $display("FAIL cont_count got %0d want %0d", frame_count, dn - 1); end
                if (dn == 3) continuous = 1'b0;
            end
            step;
            n++;
        end
        checks++; if (dn !== 3) begin errors++; $display("FAIL cont_frames got %0d want 3", dn); end
        checks++; if (idle_seen !== 0) begin errors++; $display("FAIL cont_idle got %0d idle cycles want 0", idle_seen); end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL cont_final_count got %0d want 3", frame_count); end
        checks++; if (wr_total - base !== 96) begin errors++; $display("FAIL cont_writes got %0d want 96", wr_total - base); end
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop busy got %b want 0", busy); end
    endtask

    task automatic test_mid_reset;
        int base, n;
        do_reset;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        repeat (10) step;
        checks++; if (pixel_x !== 10'd2 || pixel_y !== 10'd1) begin errors++; $display("FAIL midrst_pixel got %0d,%0d want 2,1", pixel_x, pixel_y); end
        rst_n = 1'b0;
        step;
        checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_abort we/busy got %b/%b want 0/0", fb_we, busy); end
        checks++; if (pixel_x !== 10'd0 || frame_count !== 16'd0) begin errors++; $display("FAIL midrst_state got %0d/%0d want 0/0", pixel_x, frame_count); end
        rst_n = 1'b1;
        base = wr_total;
        repeat (10) step;
        checks++; if (wr_total !== base) begin errors++; $display("FAIL midrst_stray got %0d writes want 0", wr_total - base); end
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        repeat (3) step;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", fb_we); end
        step;
        checks++; if (fb_we !== 1'b1 || fb_addr !== 19'd0) begin errors++; $display("FAIL midrst_first got %b/%0d want 1/0", fb_we, fb_addr); end
        n = 0;
        while (busy && n < 200) begin step; n++; end
        checks++; if (busy !== 1'b0 || frame_count !== 16'd1) begin errors++; $display("FAIL midrst_finish busy/count got %b/%0d want 0/1", busy, frame_count); end
    endtask

    task automatic test_ignore_start;
        int base_d, base_w;
        do_reset;
        base_d = done_total;
        base_w = wr_total;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (6) step;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (27) step;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (60) step;
        checks++; if (done_total - base_d !== 1) begin errors++; $display("FAIL ignore_done got %0d want 1", done_total - base_d); end
        checks++; if (wr_total - base_w !== 32) begin errors++; $display("FAIL ignore_writes got %0d want 32", wr_total - base_w); end
        checks++; if (busy !== 1'b0 || frame_count !== 16'd1) begin errors++; $display("FAIL ignore_end busy/count got %b/%0d want 0/1", busy, frame_count); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_shadow;
        test_continuous;
        test_mid_reset;
        test_ignore_start;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
